// File: rtl/port_pkg.sv
// -----------------------------------------------------------------------------
// port_pkg -- shared constants and helpers for the per-port interrupt block.
//
// Holds the DCR word offsets of the port interrupt registers, the default
// implemented-bit mask for PxIS/PxIE, the PxICC field layout, and small
// helpers that decode/clean a PxICC value.
//
// The PxICC helpers are only consumed when PORT_INTR_COALESCE_EN is defined.
// -----------------------------------------------------------------------------
package port_pkg;

    // DCR word offsets (DCR_ABus[5:9])
    localparam logic [4:0] PXIS_OFS  = 5'h04;
    localparam logic [4:0] PXIE_OFS  = 5'h05;
    localparam logic [4:0] PXICC_OFS = 5'h06;

    // Implemented PxIS/PxIE bits when the instance does not override the mask
    localparam logic [31:0] IS_MASK_DFLT = 32'hFDC0_00FF;

    // PxICC field positions
    localparam int PXICC_CC_LSB = 0;
    localparam int PXICC_CC_MSB = 7;
    localparam int PXICC_TV_LSB = 8;
    localparam int PXICC_TV_MSB = 23;
    localparam int PXICC_EN_BIT = 31;

    typedef struct packed {
        logic        en;
        logic [15:0] tv;
        logic [7:0]  cc;
    } coal_cfg_t;

    function automatic coal_cfg_t pxicc_decode(input logic [31:0] v);
        coal_cfg_t c;
        c.en = v[PXICC_EN_BIT];
        c.tv = v[PXICC_TV_MSB:PXICC_TV_LSB];
        c.cc = v[PXICC_CC_MSB:PXICC_CC_LSB];
        return c;
    endfunction

    // Keep only the defined PxICC fields so reserved bits read back as 0
    function automatic logic [31:0] pxicc_clean(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        r[PXICC_EN_BIT]                = v[PXICC_EN_BIT];
        r[PXICC_TV_MSB:PXICC_TV_LSB]   = v[PXICC_TV_MSB:PXICC_TV_LSB];
        r[PXICC_CC_MSB:PXICC_CC_LSB]   = v[PXICC_CC_MSB:PXICC_CC_LSB];
        return r;
    endfunction

endpackage

// File: rtl/intr_coalesce.sv
// -----------------------------------------------------------------------------
// intr_coalesce -- interrupt coalescing gate for one port.
//
// Counts cycles carrying an event on an enabled bit and runs a timeout from
// the first uncounted event. When the count reaches CC or the timer reaches
// TV the FSM passes through FIRE, which opens the output gate; the gate stays
// open while any enabled status bit is pending. Coalescing is bypassed
// (allow=1) when EN=0, CC=0 or TV=0.
//
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset
//   cfg      in   decoded PxICC (en, tv, cc)
//   evt      in   an enabled status bit is being set this cycle
//   pending  in   (PxIS & PxIE) != 0
//   allow    out  permit the interrupt output to follow PxIS & PxIE
// -----------------------------------------------------------------------------
module intr_coalesce
    import port_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  coal_cfg_t cfg,
    input  logic      evt,
    input  logic      pending,
    output logic      allow
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_FIRE  = 2'd2;

    logic [1:0]  state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [15:0] tmr_reg, tmr_next;
    logic        gate_reg, gate_next;
    logic        active;

    assign active = cfg.en && (cfg.cc != 8'd0) && (cfg.tv != 16'd0);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tmr_next   = tmr_reg;
        gate_next  = gate_reg & pending;
        if (!active) begin
            state_next = ST_IDLE;
            cnt_next   = 8'd0;
            tmr_next   = 16'd0;
            gate_next  = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (evt) begin
                        cnt_next   = 8'd1;
                        tmr_next   = 16'd0;
                        state_next = (cfg.cc == 8'd1) ? ST_FIRE : ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    tmr_next = tmr_reg + 16'd1;
                    if (evt) begin
                        cnt_next = cnt_reg + 8'd1;
                    end
                    // Count threshold and timeout landing together still
                    // make only one trip through FIRE.
                    if ((evt && (cnt_reg + 8'd1 >= cfg.cc)) ||
                        (tmr_reg + 16'd1 >= cfg.tv)) begin
                        state_next = ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    state_next = ST_IDLE;
                    cnt_next   = 8'd0;
                    tmr_next   = 16'd0;
                    gate_next  = 1'b1;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 8'd0;
            tmr_reg   <= 16'd0;
            gate_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tmr_reg   <= tmr_next;
            gate_reg  <= gate_next;
        end
    end

    // FIRE opens the gate in the same cycle so the output register sees it
    assign allow = !active || gate_reg || (state_reg == ST_FIRE);

endmodule

// File: rtl/port_intr.sv
// -----------------------------------------------------------------------------
// port_intr -- per-port interrupt status/enable registers on the DCR bus.
//
// Registers (DCR_ABus[1:4] must equal C_PORT_ID):
//   5'h04 PxIS  status, set by port_evt_set, write-1-to-clear (set wins)
//   5'h05 PxIE  enable, read/write
//   5'h06 PxICC coalescing control (only with PORT_INTR_COALESCE_EN defined,
//               otherwise reads 0 and ignores writes)
// A DCR write commits once, on the first cycle DCR_Write is high.
//
// Ports:
//   sys_clk0           in   clock (same as DCR clock)
//   sys_rst_n          in   synchronous active-low reset
//   DCR_Read           in   read strobe (reads have no side effects)
//   DCR_Write          in   write strobe
//   DCR_ABus[0:9]      in   [1:4] port number, [5:9] word offset
//   DCR_Sl_DBus[0:31]  in   write data, internal bit n = DCR_Sl_DBus[31-n]
//   port_evt_set       in   single-cycle PxIS set pulses
//   Sl_dcrDbus_port    out  combinational read data
//   port2ghc_PxISIE    out  registered PxIS & PxIE (gated when coalescing)
//   port2ghc_ips_set   out  port_evt_set[15:0] delayed one cycle
//   port2ghc_intr_req  out  port2ghc_PxISIE[15:0]
//
// Build option: PORT_INTR_COALESCE_EN adds PxICC and the intr_coalesce gate.
// -----------------------------------------------------------------------------
module port_intr
    import port_pkg::*;
#(
    parameter logic [3:0]  C_PORT_ID = 4'b0010,
    parameter logic [31:0] C_IS_MASK = IS_MASK_DFLT
) (
    input  logic        sys_clk0,
    input  logic        sys_rst_n,
    input  logic        DCR_Read,
    input  logic        DCR_Write,
    input  logic [0:9]  DCR_ABus,
    input  logic [0:31] DCR_Sl_DBus,
    input  logic [31:0] port_evt_set,
    output logic [31:0] Sl_dcrDbus_port,
    output logic [31:0] port2ghc_PxISIE,
    output logic [15:0] port2ghc_ips_set,
    output logic [15:0] port2ghc_intr_req
);

    logic [3:0]  addr_port;
    logic [4:0]  addr_ofs;
    logic        sel;
    logic [31:0] wr_data;
    logic        wr_seen_reg;
    logic        wr_hold_reg;
    logic        wr_commit;
    logic        wr_pxis, wr_pxie;
    logic [31:0] pxis_reg, pxis_next;
    logic [31:0] pxie_reg, pxie_next;
    logic [31:0] pending_vec;
    logic [31:0] pxisie_reg;
    logic [15:0] ips_set_reg;
    logic        irq_allow;
    logic [31:0] rd_data;

    // Reads are side-effect free and address bit 0 is outside the decode
    logic unused_inputs;
    assign unused_inputs = DCR_Read ^ DCR_ABus[0];

    assign addr_port = DCR_ABus[1:4];
    assign addr_ofs  = DCR_ABus[5:9];
    assign sel       = (addr_port == C_PORT_ID);
    // Plain assignment reverses the big-endian bus: wr_data[n] = DCR_Sl_DBus[31-n]
    assign wr_data   = DCR_Sl_DBus;

    // wr_hold_reg remembers a write that was already high across reset so it
    // cannot commit until DCR_Write has dropped and risen again.
    always_ff @(posedge sys_clk0) begin
        if (!sys_rst_n) begin
            wr_seen_reg <= 1'b0;
            wr_hold_reg <= DCR_Write;
        end else begin
            wr_seen_reg <= DCR_Write;
            wr_hold_reg <= wr_hold_reg & DCR_Write;
        end
    end

    assign wr_commit = DCR_Write && !wr_seen_reg && !wr_hold_reg && sel;
    assign wr_pxis   = wr_commit && (addr_ofs == PXIS_OFS);
    assign wr_pxie   = wr_commit && (addr_ofs == PXIE_OFS);

    // Per-bit next state; unimplemented bits are forced to 0
    for (genvar gi = 0; gi < 32; gi++) begin : g_bit
        assign pxis_next[gi] = C_IS_MASK[gi] &
            (port_evt_set[gi] | (pxis_reg[gi] & ~(wr_pxis & wr_data[gi])));
        assign pxie_next[gi] = C_IS_MASK[gi] &
            (wr_pxie ? wr_data[gi] : pxie_reg[gi]);
    end

    assign pending_vec = pxis_reg & pxie_reg;

    always_ff @(posedge sys_clk0) begin
        if (!sys_rst_n) begin
            pxis_reg    <= '0;
            pxie_reg    <= '0;
            pxisie_reg  <= '0;
            ips_set_reg <= '0;
        end else begin
            pxis_reg    <= pxis_next;
            pxie_reg    <= pxie_next;
            pxisie_reg  <= pending_vec & {32{irq_allow}};
            ips_set_reg <= port_evt_set[15:0];
        end
    end

`ifdef PORT_INTR_COALESCE_EN
    logic        wr_pxicc;
    logic [31:0] pxicc_reg;
    coal_cfg_t   coal_cfg;
    logic        coal_evt;
    logic        coal_pending;

    assign wr_pxicc = wr_commit && (addr_ofs == PXICC_OFS);

    always_ff @(posedge sys_clk0) begin
        if (!sys_rst_n) begin
            pxicc_reg <= '0;
        end else if (wr_pxicc) begin
            pxicc_reg <= pxicc_clean(wr_data);
        end
    end

    assign coal_cfg     = pxicc_decode(pxicc_reg);
    assign coal_evt     = |(port_evt_set & pxie_reg);
    assign coal_pending = |pending_vec;

    intr_coalesce u_coalesce (
        .clk     (sys_clk0),
        .rst_n   (sys_rst_n),
        .cfg     (coal_cfg),
        .evt     (coal_evt),
        .pending (coal_pending),
        .allow   (irq_allow)
    );
`else
    assign irq_allow = 1'b1;
`endif

    always_comb begin
        rd_data = 32'h0;
        if (sel) begin
            case (addr_ofs)
                PXIS_OFS:  rd_data = pxis_reg;
                PXIE_OFS:  rd_data = pxie_reg;
`ifdef PORT_INTR_COALESCE_EN
                PXICC_OFS: rd_data = pxicc_reg;
`else
                PXICC_OFS: rd_data = 32'h0;
`endif
                default:   rd_data = 32'h0;
            endcase
        end
    end

    assign Sl_dcrDbus_port   = rd_data;
    assign port2ghc_PxISIE   = pxisie_reg;
    assign port2ghc_ips_set  = ips_set_reg;
    assign port2ghc_intr_req = pxisie_reg[15:0];

endmodule

// File: tb/tb_port_intr.sv
// -----------------------------------------------------------------------------
// tb_port_intr -- directed self-checking bench for port_intr.
// Expected values are queued when stimulus is applied and popped when the
// corresponding DUT output is sampled (1 ns after the rising edge).
// -----------------------------------------------------------------------------
module tb_port_intr;

    logic        sys_clk0;
    logic        sys_rst_n;
    logic        DCR_Read;
    logic        DCR_Write;
    logic [0:9]  DCR_ABus;
    logic [0:31] DCR_Sl_DBus;
    logic [31:0] port_evt_set;
    logic [31:0] Sl_dcrDbus_port;
    logic [31:0] port2ghc_PxISIE;
    logic [15:0] port2ghc_ips_set;
    logic [15:0] port2ghc_intr_req;

    localparam logic [3:0] MY_PORT    = 4'b0010;
    localparam logic [3:0] OTHER_PORT = 4'b0011;
    localparam logic [4:0] O_PXIS     = 5'h04;
    localparam logic [4:0] O_PXIE     = 5'h05;
    localparam logic [4:0] O_PXICC    = 5'h06;
    localparam logic [4:0] O_UNDEF    = 5'h07;

    int checks = 0;
    int errors = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    port_intr #(
        .C_PORT_ID (4'b0010),
        .C_IS_MASK (32'hFDC0_00FF)
    ) dut (
        .sys_clk0          (sys_clk0),
        .sys_rst_n         (sys_rst_n),
        .DCR_Read          (DCR_Read),
        .DCR_Write         (DCR_Write),
        .DCR_ABus          (DCR_ABus),
        .DCR_Sl_DBus       (DCR_Sl_DBus),
        .port_evt_set      (port_evt_set),
        .Sl_dcrDbus_port   (Sl_dcrDbus_port),
        .port2ghc_PxISIE   (port2ghc_PxISIE),
        .port2ghc_ips_set  (port2ghc_ips_set),
        .port2ghc_intr_req (port2ghc_intr_req)
    );

    initial sys_clk0 = 1'b0;
    always #5 sys_clk0 = ~sys_clk0;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge sys_clk0);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=%08h expected=queued_value", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%08h expected=%08h", t, obs, e);
            end
            $display("txn %-18s observed=%08h expected=%08h", t, obs, e);
        end
    endtask

    task automatic set_addr(input logic [3:0] port, input logic [4:0] ofs);
        DCR_ABus = {1'b0, port, ofs};
    endtask

    task automatic dcr_write(input logic [3:0] port, input logic [4:0] ofs,
                             input logic [31:0] data);
        set_addr(port, ofs);
        DCR_Sl_DBus = data;
        DCR_Write   = 1'b1;
        step();
        DCR_Write   = 1'b0;
        step();
    endtask

    task automatic expect_reg(input string tag, input logic [3:0] port,
                              input logic [4:0] ofs, input logic [31:0] exp);
        logic [31:0] obs;
        push_exp(tag, exp);
        set_addr(port, ofs);
        DCR_Read = 1'b1;
        #1;
        obs = Sl_dcrDbus_port;
        DCR_Read = 1'b0;
        check(obs);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
        push_exp(tag, exp);
        check(obs);
    endtask

    task automatic pulse_evt(input logic [31:0] v);
        port_evt_set = v;
        step();
        port_evt_set = '0;
    endtask

    // Bounded wait for PxISIE[0]; a timeout shows up as a compare of 0 vs 1
    task automatic wait_isie(input string tag, input int max_cycles);
        logic got;
        got = 1'b0;
        push_exp(tag, 32'h1);
        for (int i = 0; i < max_cycles && !got; i++) begin
            step();
            got = port2ghc_PxISIE[0];
        end
        check({31'h0, got});
    endtask

    initial begin
        sys_rst_n    = 1'b0;
        DCR_Read     = 1'b0;
        DCR_Write    = 1'b0;
        DCR_ABus     = '0;
        DCR_Sl_DBus  = '0;
        port_evt_set = '0;
        step();
        step();
        expect_out("rst_pxisie", port2ghc_PxISIE, 32'h0);
        expect_out("rst_ips", {16'h0, port2ghc_ips_set}, 32'h0);
        sys_rst_n = 1'b1;
        step();
        expect_reg("rst_pxis", MY_PORT, O_PXIS, 32'h0);
        expect_reg("rst_pxie", MY_PORT, O_PXIE, 32'h0);

        // Basic enable + event path
        dcr_write(MY_PORT, O_PXIE, 32'h1);
        expect_reg("pxie_load", MY_PORT, O_PXIE, 32'h1);
        pulse_evt(32'h1);
        expect_out("ips_set_1", {16'h0, port2ghc_ips_set}, 32'h1);
        expect_out("pxisie_lag", port2ghc_PxISIE, 32'h0);
        expect_reg("pxis_set", MY_PORT, O_PXIS, 32'h1);
        step();
        expect_out("pxisie_1", port2ghc_PxISIE, 32'h1);
        expect_out("intr_req_1", {16'h0, port2ghc_intr_req}, 32'h1);
        expect_out("ips_set_0", {16'h0, port2ghc_ips_set}, 32'h0);

        // Set beats clear in the same cycle
        set_addr(MY_PORT, O_PXIS);
        DCR_Sl_DBus  = 32'h1;
        DCR_Write    = 1'b1;
        port_evt_set = 32'h1;
        step();
        DCR_Write    = 1'b0;
        port_evt_set = '0;
        step();
        expect_reg("set_wins", MY_PORT, O_PXIS, 32'h1);
        dcr_write(MY_PORT, O_PXIS, 32'h1);
        expect_reg("w1c_clear", MY_PORT, O_PXIS, 32'h0);
        step();
        expect_out("pxisie_clr", port2ghc_PxISIE, 32'h0);

        // Held write commits once only
        set_addr(MY_PORT, O_PXIS);
        DCR_Sl_DBus = 32'h1;
        DCR_Write   = 1'b1;
        step();
        port_evt_set = 32'h1;
        step();
        port_evt_set = '0;
        step();
        DCR_Write = 1'b0;
        step();
        expect_reg("held_write", MY_PORT, O_PXIS, 32'h1);
        dcr_write(MY_PORT, O_PXIS, 32'h1);

        // Selective W1C and unimplemented status bits
        pulse_evt(32'h0000_0106);
        expect_reg("unimpl_bit8", MY_PORT, O_PXIS, 32'h0000_0006);
        dcr_write(MY_PORT, O_PXIS, 32'h0000_0002);
        expect_reg("w1c_select", MY_PORT, O_PXIS, 32'h0000_0004);
        dcr_write(MY_PORT, O_PXIS, 32'hFFFF_FFFF);

        // Port decode and enable mask
        dcr_write(OTHER_PORT, O_PXIE, 32'hFFFF_FFFF);
        expect_reg("other_port_wr", MY_PORT, O_PXIE, 32'h1);
        expect_reg("other_port_rd", OTHER_PORT, O_PXIE, 32'h0);
        dcr_write(MY_PORT, O_PXIE, 32'hFFFF_FFFF);
        expect_reg("pxie_mask", MY_PORT, O_PXIE, 32'hFDC0_00FF);
        expect_reg("undef_ofs", MY_PORT, O_UNDEF, 32'h0);
        pulse_evt(32'hFFFF_FFFF);
        expect_reg("pxis_mask", MY_PORT, O_PXIS, 32'hFDC0_00FF);
        step();
        expect_out("pxisie_all", port2ghc_PxISIE, 32'hFDC0_00FF);
        expect_out("intr_req_all", {16'h0, port2ghc_intr_req}, 32'h0000_00FF);
        dcr_write(MY_PORT, O_PXIS, 32'hFFFF_FFFF);

        // Reset in the middle of a write
        pulse_evt(32'h5);
        expect_reg("pre_rst_pxis", MY_PORT, O_PXIS, 32'h5);
        set_addr(MY_PORT, O_PXIE);
        DCR_Sl_DBus  = 32'h5;
        DCR_Write    = 1'b1;
        sys_rst_n    = 1'b0;
        port_evt_set = 32'h1;
        step();
        sys_rst_n    = 1'b1;
        port_evt_set = '0;
        expect_out("mrst_ips", {16'h0, port2ghc_ips_set}, 32'h0);
        step();
        step();
        expect_out("mrst_pxisie", port2ghc_PxISIE, 32'h0);
        expect_out("mrst_intr", {16'h0, port2ghc_intr_req}, 32'h0);
        DCR_Write = 1'b0;
        step();
        expect_reg("mrst_pxis", MY_PORT, O_PXIS, 32'h0);
        expect_reg("mrst_no_commit", MY_PORT, O_PXIE, 32'h0);
        dcr_write(MY_PORT, O_PXIE, 32'h5);
        expect_reg("post_rst_wr", MY_PORT, O_PXIE, 32'h5);

`ifdef PORT_INTR_COALESCE_EN
        dcr_write(MY_PORT, O_PXIE, 32'h1);
        dcr_write(MY_PORT, O_PXICC, 32'h8000_0A03);
        expect_reg("pxicc_rd", MY_PORT, O_PXICC, 32'h8000_0A03);

        // Count threshold reached well before the timeout
        pulse_evt(32'h1);
        step();
        pulse_evt(32'h1);
        step();
        expect_out("cnt_hold", port2ghc_PxISIE, 32'h0);
        pulse_evt(32'h1);
        step();
        expect_out("cnt_fire", port2ghc_PxISIE, 32'h1);
        dcr_write(MY_PORT, O_PXIS, 32'h1);
        expect_out("cnt_deassert", port2ghc_PxISIE, 32'h0);

        // Three events five clocks apart
        pulse_evt(32'h1);
        for (int i = 0; i < 4; i++) step();
        pulse_evt(32'h1);
        for (int i = 0; i < 4; i++) step();
        expect_out("three_hold", port2ghc_PxISIE, 32'h0);
        pulse_evt(32'h1);
        wait_isie("three_fire", 6);
        dcr_write(MY_PORT, O_PXIS, 32'h1);
        expect_out("three_deassert", port2ghc_PxISIE, 32'h0);

        // Single event fires on the timeout
        pulse_evt(32'h1);
        for (int i = 0; i < 7; i++) step();
        expect_out("tmo_hold", port2ghc_PxISIE, 32'h0);
        wait_isie("tmo_fire", 8);
        dcr_write(MY_PORT, O_PXIS, 32'h1);

        // EN=0 restores direct pass-through
        dcr_write(MY_PORT, O_PXICC, 32'h0000_0A03);
        pulse_evt(32'h1);
        step();
        expect_out("en0_pass", port2ghc_PxISIE, 32'h1);
`else
        dcr_write(MY_PORT, O_PXICC, 32'h8000_0A03);
        expect_reg("pxicc_absent", MY_PORT, O_PXICC, 32'h0);
        pulse_evt(32'h1);
        step();
        expect_out("no_coal_pass", port2ghc_PxISIE, 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
